// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus address/strobe pair shared by the load/store unit and MMIO peripherals.
interface uart_tx_mmio_if;
  logic [15:0] DA;
  logic        RW;

  modport master (output DA, output RW);
  modport slave  (input  DA, input  RW);
endinterface

// File: rtl/uart_tx_mmio.sv
// MMIO UART TX: stores push a FIFO (full drops + OVF), start bit 1 cycle after push, loads are combinational.
// Build option UART_TX_PARITY_EN inserts an even-parity bit per frame and reports it in STATUS bit9.
module uart_tx_mmio #(
  parameter logic [15:0] BASE        = 16'hFF00,
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic          CK,
  input  logic          RST,
  uart_tx_mmio_if.slave bus,
  inout  wire  [15:0]   DD,
  output logic          TXD,
  output logic          TX_EMPTY
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_BIT = 1'b1;
`else
  localparam logic PAR_BIT = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic          rw_q;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          tx_empty_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic        sel, ws, full, empty, busy, push, push_ok, pop, launch, boundary;
  logic [1:0]  off;
  logic [15:0] status, rdata;

  assign sel     = (bus.DA[15:2] == BASE[15:2]);
  assign off     = bus.DA[1:0];
  // Only the falling edge of RW counts, so a stretched store still acts once.
  assign ws      = sel & ~bus.RW & rw_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign busy    = (state_q != S_IDLE);
  assign push    = ws & (off == 2'd0);
  assign push_ok = push & ~full;

  assign status = {6'b0, PAR_BIT, 5'(count_q), ovf_q, busy, empty, full};

  always_comb begin
    rdata = 16'h0000;
    unique case (off)
      2'd1:    rdata = status;
      2'd2:    rdata = div_q;
      default: rdata = 16'h0000;
    endcase
  end

  assign DD = (sel && bus.RW) ? rdata : 16'hzzzz;

  always_comb begin
    ovf_d = ovf_q;
    div_d = div_q;
    if (push && full)
      ovf_d = 1'b1;
    else if (ws && (off == 2'd1) && DD[3])
      ovf_d = 1'b0;
    if (ws && (off == 2'd2))
      div_d = DD;
  end

  assign boundary = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    launch  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: launch = ~empty;
      S_START: begin
        if (boundary) begin
          txd_d   = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (boundary) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = par_q;
            state_d = S_PARITY;
`else
            txd_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            txd_d = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (boundary) begin
          txd_d   = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (boundary) begin
          state_d = S_IDLE;
          launch  = ~empty;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Reloading from div_q at every boundary lets a divisor change land between bits.
    if (state_q != S_IDLE)
      cnt_d = boundary ? div_q : cnt_q - 16'd1;
    if (launch) begin
      sh_d    = mem_q[rd_ptr_q];
      txd_d   = 1'b0;
      cnt_d   = div_q;
      state_d = S_START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rd_ptr_q];
`endif
    end
  end

  assign pop      = launch;
  assign count_d  = count_q + CW'(push_ok) - CW'(pop);
  assign wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

  always_ff @(posedge CK) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= DD[7:0];
  end

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      rw_q       <= 1'b1;
      ovf_q      <= 1'b0;
      div_q      <= DEFAULT_DIV;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      idx_q      <= 3'd0;
      sh_q       <= 8'd0;
      txd_q      <= 1'b1;
      tx_empty_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      rw_q       <= bus.RW;
      ovf_q      <= ovf_d;
      div_q      <= div_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      txd_q      <= txd_d;
      tx_empty_q <= (count_d == '0) && (state_d == S_IDLE);
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign TXD      = txd_q;
  assign TX_EMPTY = tx_empty_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: serial frames and bus reads are checked by separate monitors.
module tb_uart_tx_mmio;
  localparam logic [15:0] BASE = 16'hFF00;
`ifdef UART_TX_PARITY_EN
  localparam int          NB   = 11;
  localparam logic [15:0] ST_P = 16'h0200;
`else
  localparam int          NB   = 10;
  localparam logic [15:0] ST_P = 16'h0000;
`endif

  logic        CK = 1'b0;
  logic        RST = 1'b0;
  logic        TXD, TX_EMPTY;
  wire  [15:0] dd;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_dd = 16'h0000;

  // The pull-up makes an undriven bus read back as all ones.
  pullup (dd);
  assign dd = tb_drv ? tb_dd : 16'hzzzz;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(.BASE(BASE), .DEPTH(8), .DEFAULT_DIV(16'd433)) dut (
    .CK(CK), .RST(RST), .bus(bus), .DD(dd), .TXD(TXD), .TX_EMPTY(TX_EMPTY)
  );

  always #5 CK = ~CK;

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int mon_div = 433;
  logic [7:0]  exp_q[$];
  logic [15:0] rd_exp_q[$];
  string       rd_nm_q[$];
  event        rd_ev;

  always @(posedge CK) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, input int hold);
    @(negedge CK);
    bus.DA = a;
    tb_dd  = d;
    tb_drv = 1'b1;
    bus.RW = 1'b0;
    repeat (hold) @(negedge CK);
    bus.RW = 1'b1;
    tb_drv = 1'b0;
    bus.DA = 16'h0000;
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    bus.DA = a;
    bus.RW = 1'b1;
    tb_drv = 1'b0;
    rd_exp_q.push_back(exp);
    rd_nm_q.push_back(nm);
    #1;
    -> rd_ev;
    #1;
    bus.DA = 16'h0000;
  endtask

  initial begin : rd_mon
    forever begin
      @(rd_ev);
      check(rd_nm_q.pop_front(), 32'(dd), 32'(rd_exp_q.pop_front()));
    end
  end

  // Decodes TXD frames by sampling mid-bit and compares each byte with the queue head.
  initial begin : tx_mon
    int ph;
    int bt;
    logic [7:0] rx;
    logic [7:0] e;
    ph = -1;
    bt = 1;
    rx = 8'h00;
    forever begin
      @(negedge CK);
      if (!RST) begin
        ph = -1;
        continue;
      end
      if (ph < 0) begin
        if (TXD !== 1'b0) continue;
        ph = 0;
        bt = mon_div + 1;
      end
      if ((ph % bt) == (bt / 2)) begin
        int k;
        k = ph / bt;
        if (k >= 1 && k <= 8) begin
          rx[k-1] = TXD;
        end
`ifdef UART_TX_PARITY_EN
        else if (k == 9) begin
          check("parity_bit", 32'(TXD), 32'(^rx));
        end
`endif
        else if (k == NB - 1) begin
          check("stop_bit", 32'(TXD), 32'd1);
          if (exp_q.size() == 0) begin
            vec++;
            miss++;
            $display("FAIL tx_frame: got byte 0x%0h, expected no frame", rx);
          end else begin
            e = exp_q.pop_front();
            check("tx_frame", 32'(rx), 32'(e));
          end
        end
      end
      ph++;
      if (ph == NB * bt) ph = -1;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] fb;
    logic [7:0]  b;
    int t0;
    int n;

    bus.DA = 16'h0000;
    bus.RW = 1'b1;
    repeat (3) @(negedge CK);
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_tx_empty", 32'(TX_EMPTY), 32'd1);
    RST = 1'b1;
    @(negedge CK);
    bus_rd(BASE + 16'd2, 16'd433, "rst_bauddiv");
    bus_rd(BASE + 16'd1, 16'h0002 | ST_P, "rst_status");
    check("idle_txd", 32'(TXD), 32'd1);
    check("idle_tx_empty", 32'(TX_EMPTY), 32'd1);

    // Single byte at 4 cycles per bit, checked cycle by cycle.
    bus_wr(BASE + 16'd2, 16'd3, 1);
    mon_div = 3;
    b = 8'hA5;
    fb = 16'h0000;
    for (int i = 0; i < 8; i++) fb[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    fb[9] = ^b;
`endif
    fb[NB-1] = 1'b1;
    exp_q.push_back(b);
    bus_wr(BASE, 16'h00A5, 1);
    check("pre_start_txd", 32'(TXD), 32'd1);
    for (int c = 0; c < NB * 4; c++) begin
      @(negedge CK);
      check($sformatf("txd_c%0d", c), 32'(TXD), 32'(fb[c/4]));
      if (c == NB * 4 - 1) check("tx_empty_last_cycle", 32'(TX_EMPTY), 32'd0);
    end
    @(negedge CK);
    check("tx_empty_done", 32'(TX_EMPTY), 32'd1);

    // Overflow: one byte pops at once, eight fill the FIFO, the tenth is dropped.
    bus_wr(BASE + 16'd2, 16'd100, 1);
    mon_div = 100;
    t0 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'(i));
      bus_wr(BASE, 16'(i), 1);
      if (i == 0) t0 = cyc;
    end
    bus_rd(BASE + 16'd1, 16'h008D | ST_P, "ovf_status");
    bus_wr(BASE + 16'd1, 16'h0008, 1);
    bus_rd(BASE + 16'd1, 16'h0085 | ST_P, "ovf_cleared");
    n = 0;
    while (TX_EMPTY !== 1'b1 && n < 12000) begin
      @(negedge CK);
      n++;
    end
    // Nine back-to-back frames from the first start bit, plus the push-to-start cycle.
    check("ovf_drain_cycles", 32'(cyc - t0), 32'(9 * NB * 101 + 1));

    // Stretched store acts once; the first byte keeps the engine busy.
    exp_q.push_back(8'h5A);
    bus_wr(BASE, 16'h005A, 1);
    exp_q.push_back(8'h41);
    bus_wr(BASE, 16'h0041, 3);
    bus_rd(BASE + 16'd1, 16'h0014 | ST_P, "ws_edge_status");

    bus_wr(BASE + 16'd3, 16'hFFFF, 1);
    bus_wr(BASE + 16'd4, 16'h0001, 1);
    bus_rd(BASE + 16'd1, 16'h0014 | ST_P, "decode_status");
    bus_rd(BASE + 16'd2, 16'd100, "decode_bauddiv");
    bus_rd(BASE + 16'd4, 16'hFFFF, "decode_dd_z");
    bus_rd(BASE + 16'd0, 16'h0000, "txdata_reads_0");
    bus_rd(BASE + 16'd3, 16'h0000, "reg3_reads_0");
    n = 0;
    while (TX_EMPTY !== 1'b1 && n < 3000) begin
      @(negedge CK);
      n++;
    end
    check("ws_drain", 32'(TX_EMPTY), 32'd1);

    // Reset during data bit 3 of 0xC3 (bit 3 is 0).
    bus_wr(BASE + 16'd2, 16'd3, 1);
    mon_div = 3;
    exp_q.push_back(8'hC3);
    bus_wr(BASE, 16'h00C3, 1);
    repeat (18) @(negedge CK);
    check("pre_rst_txd", 32'(TXD), 32'd0);
    #2;
    RST = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_txd", 32'(TXD), 32'd1);
    check("rst_mid_tx_empty", 32'(TX_EMPTY), 32'd1);
    repeat (3) @(negedge CK);
    RST = 1'b1;
    repeat (2) @(negedge CK);
    bus_rd(BASE + 16'd1, 16'h0002 | ST_P, "post_rst_status");
    bus_rd(BASE + 16'd2, 16'd433, "post_rst_bauddiv");
    repeat (10) @(negedge CK);
    check("post_rst_txd_idle", 32'(TXD), 32'd1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CK);
      n++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
